// File: rtl/mprj_wb_responder.sv
// mprj_wb_responder: Wishbone slave with a 32-byte register window at BASE_ADDR.
// It provides four scratch registers, a free-running counter, and compare/match interrupt logic.
// Optional feature macro: WB_RESPONDER_IRQ_EN enables COMPARE, STATUS, CTRL.IRQ_EN and irq_o.
// When the macro is undefined, those registers read 0, writes to them are ignored, and irq_o is 0.
module mprj_wb_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned WCW = 4;

`ifdef WB_RESPONDER_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             we_q, we_d;
  logic [3:0]       sel_q, sel_d;
  logic [DW-1:0]    wdat_q, wdat_d;
  logic [DW-1:0]    rdat_q, rdat_d;
  logic             ack_q, ack_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic [DW-1:0]    scratch_q [4];
  logic [DW-1:0]    scratch_d [4];
  logic [1:0]       ctrl_q, ctrl_d;
  logic [DW-1:0]    count_q, count_d;
  logic [DW-1:0]    compare_q, compare_d;
  logic             match_q, match_d;

  logic             hit_c;
  logic             commit_c;
  logic [2:0]       c_idx;
  logic             c_we;
  logic [3:0]       c_sel;
  logic [DW-1:0]    c_dat;
  logic [DW-1:0]    rd_c;
  logic             unused_adr_c;

  assign unused_adr_c = ^wbs_adr_i[1:0];

  // Byte-lane merge of write data into an existing register value
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [3:0]    sel);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Read mux over current register values
  always_comb begin
    rd_c = '0;
    case (c_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_c = scratch_q[c_idx[1:0]];
      3'd4:                   rd_c = {30'd0, ctrl_q};
      3'd5:                   rd_c = count_q;
      3'd6:                   rd_c = compare_q;
      3'd7:                   rd_c = {31'd0, match_q};
    endcase
  end

  // Next-state logic: bus FSM, register writes, counter and match
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    commit_c  = 1'b0;

    hit_c = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);

    // In IDLE the live bus is the request (zero-wait commit); later the captured copy is used
    c_idx = (state_q == ST_IDLE) ? wbs_adr_i[4:2] : idx_q;
    c_we  = (state_q == ST_IDLE) ? wbs_we_i       : we_q;
    c_sel = (state_q == ST_IDLE) ? wbs_sel_i      : sel_q;
    c_dat = (state_q == ST_IDLE) ? wbs_dat_i      : wdat_q;

    case (state_q)
      ST_IDLE: begin
        if (hit_c) begin
          idx_d  = wbs_adr_i[4:2];
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          wdat_d = wbs_dat_i;
          if (WAIT_STATES == 0) begin
            state_d  = ST_ACK;
            commit_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WCW'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == '0) begin
          state_d  = ST_ACK;
          commit_c = 1'b1;
        end else begin
          wcnt_d = wcnt_q - WCW'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Counter and match run every cycle; a committed write below overrides the increment
    count_d = count_q + DW'(ctrl_q[0]);
    match_d = match_q | (HAS_IRQ & ctrl_q[0] & (count_q == compare_q));

    if (commit_c) rdat_d = rd_c;

    if (commit_c && c_we) begin
      case (c_idx)
        3'd0, 3'd1, 3'd2, 3'd3:
          scratch_d[c_idx[1:0]] = merge(scratch_q[c_idx[1:0]], c_dat, c_sel);
        3'd4: if (c_sel[0]) ctrl_d = {HAS_IRQ & c_dat[1], c_dat[0]};
        3'd5: count_d = merge(count_q, c_dat, c_sel);
        3'd6: if (HAS_IRQ) compare_d = merge(compare_q, c_dat, c_sel);
        3'd7: begin
          // Clear only if no set event this edge; set wins
          if (HAS_IRQ && c_sel[0] && c_dat[0])
            match_d = HAS_IRQ & ctrl_q[0] & (count_q == compare_q);
        end
      endcase
    end

    ack_d = (state_q == ST_ACK);
    dat_d = (state_q == ST_ACK && !we_q) ? rdat_q : '0;
  end

  // State and register flops with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      scratch_q <= '{default: '0};
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

`ifdef WB_RESPONDER_IRQ_EN
  assign irq_o = match_q & ctrl_q[1];
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_mprj_wb_responder.sv
// Scoreboard bench for mprj_wb_responder (WAIT_STATES=1, default BASE_ADDR).
module tb_mprj_wb_responder;

  localparam int unsigned WS = 1;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        irq;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mprj_wb_responder #(.BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .irq_o    (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected read-data word
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
      end else begin
        check("ack_data", rdat, exp_q.pop_front());
      end
    end
  end

  // One full transfer; expected read data is queued for the monitor, latency checked here
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic [31:0] exp_rd, input string name);
    int lat;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    exp_q.push_back(w ? 32'h0 : exp_rd);
    @(posedge clk);
    #1;
    stb = 1'b0; we = ~w; adr = 32'h0; sel = 4'h0; wdat = 32'hA5A5_A5A5;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({name, "_lat"}, 32'(lat), 32'(2 + WS));
    cyc = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
    xfer(1'b1, a, 4'hF, d, 32'h0, name);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_rd, input string name);
    xfer(1'b0, a, 4'hF, 32'h0, exp_rd, name);
  endtask

  task automatic no_ack(input string name, input int cycles);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ack === 1'b1) cnt++;
    end
    check(name, 32'(cnt), 32'h0);
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Basic write/read and byte lanes
    wr(BASE + 32'h00, 32'hDEAD_BEEF, "wr_s0");
    rd(BASE + 32'h00, 32'hDEAD_BEEF, "rd_s0");
    xfer(1'b1, BASE + 32'h04, 4'b0101, 32'h1122_3344, 32'h0, "wr_s1_lanes");
    rd(BASE + 32'h04, 32'h0022_0044, "rd_s1_lanes");
    wr(BASE + 32'h0C, 32'h0BAD_F00D, "wr_s3");
    rd(BASE + 32'h0C, 32'h0BAD_F00D, "rd_s3");

    // Miss: address outside the window is never acked
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0040; sel = 4'hF;
    no_ack("miss", 6);
    cyc = 1'b0; stb = 1'b0;

    // Abort: cyc dropped during WAIT on a SCRATCH2 write
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h08; sel = 4'hF; wdat = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0;
    no_ack("abort", 5);
    rd(BASE + 32'h08, 32'h0, "rd_s2_abort");

    // Counter wrap: preset all-ones, run for exactly four edges, stop
    wr(BASE + 32'h14, 32'hFFFF_FFFF, "wr_count");
    rd(BASE + 32'h14, 32'hFFFF_FFFF, "rd_count_preset");
    wr(BASE + 32'h10, 32'h1, "wr_ctrl_run");
    wr(BASE + 32'h10, 32'h0, "wr_ctrl_stop");
    rd(BASE + 32'h14, 32'h0000_0003, "rd_count_wrap");

`ifdef WB_RESPONDER_IRQ_EN
    wr(BASE + 32'h14, 32'h0, "wr_count0");
    wr(BASE + 32'h18, 32'h5, "wr_compare");
    rd(BASE + 32'h18, 32'h5, "rd_compare");
    wr(BASE + 32'h1C, 32'h1, "w1c_stale");
    rd(BASE + 32'h1C, 32'h0, "rd_status_clr");
    wr(BASE + 32'h10, 32'h3, "wr_ctrl_irq");
    check("irq_early", 32'(irq), 32'h0);
    repeat (4) @(negedge clk);
    check("irq_before_match", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_at_match", 32'(irq), 32'h1);
    rd(BASE + 32'h1C, 32'h1, "rd_status_set");
    rd(BASE + 32'h10, 32'h3, "rd_ctrl");
    wr(BASE + 32'h1C, 32'h1, "w1c_status");
    check("irq_cleared", 32'(irq), 32'h0);
    wr(BASE + 32'h10, 32'h0, "wr_ctrl_off");
`else
    wr(BASE + 32'h18, 32'h7, "wr_compare_off");
    rd(BASE + 32'h18, 32'h0, "rd_compare_off");
    wr(BASE + 32'h10, 32'h3, "wr_ctrl_off");
    rd(BASE + 32'h10, 32'h1, "rd_ctrl_off");
    repeat (10) @(negedge clk);
    check("irq_tied", 32'(irq), 32'h0);
    rd(BASE + 32'h1C, 32'h0, "rd_status_off");
    wr(BASE + 32'h10, 32'h0, "wr_ctrl_stop2");
`endif

    // Reset while a write is waiting: no ack, everything back to zero
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h0C; sel = 4'hF; wdat = 32'h5555_5555;
    @(posedge clk);
    #1 stb = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; cyc = 1'b0;
    check("rst_mid_dat", rdat, 32'h0);
    check("rst_mid_irq", 32'(irq), 32'h0);
    no_ack("rst_mid_noack", 5);
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(4 * i), 32'h0, $sformatf("rd_after_rst_%0d", i));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mprj_wb_responder.md
MPRJ_WB_RESPONDER -- requirements
Module: mprj_wb_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000: base of the 32-byte register window; bits [4:0] are ignored.
REQ-002 Parameter WAIT_STATES, default 1: cycles inserted between request capture and ack; legal range 0..15.
REQ-003 Clocking and reset: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
REQ-004 wb_clk_i  in  1  block clock.
REQ-005 wb_rst_i  in  1  synchronous active-high reset.
REQ-006 wbs_cyc_i  in  1  bus cycle valid.
REQ-007 wbs_stb_i  in  1  transfer strobe.
REQ-008 wbs_we_i  in  1  1 = write, 0 = read.
REQ-009 wbs_sel_i  in  4  byte lane enables; bit n selects data[8n+7:8n].
REQ-010 wbs_adr_i  in  32  byte address.
REQ-011 wbs_dat_i  in  32  write data.
REQ-012 wbs_ack_o  out  1  transfer acknowledge, one-cycle pulse.
REQ-013 wbs_dat_o  out  32  read data; valid only while wbs_ack_o=1, otherwise 0.
REQ-014 irq_o  out  1  level interrupt to the management core.

Function
REQ-015 A request is hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]); misses are never acked and change no state.
REQ-016 Register map by wbs_adr_i[4:2]: 0-3 SCRATCH0-3 (R/W); 4 CTRL (bit0 CNT_EN, bit1 IRQ_EN, others read 0); 5 COUNT (R/W); 6 COMPARE (R/W); 7 STATUS (bit0 MATCH, write-1-to-clear).
REQ-017 All R/W register writes honour wbs_sel_i per byte; lanes with sel=0 are unchanged.
REQ-018 FSM states IDLE, WAIT, ACK; IDLE->WAIT on hit when WAIT_STATES>0, IDLE->ACK on hit when WAIT_STATES=0; WAIT->ACK after WAIT_STATES cycles; ACK->IDLE unconditionally.
REQ-019 Address, we, sel and write data are captured at the IDLE hit edge; later bus changes do not affect the transfer.
REQ-020 Latency: hit sampled at edge N gives wbs_ack_o high for exactly the cycle after edge N+1+WAIT_STATES.
REQ-021 The write commits on the edge that enters ACK; read data is registered on the same edge from register values current at that edge.
REQ-022 wbs_cyc_i low while in WAIT aborts: return to IDLE, no ack, no write.
REQ-023 Back-to-back: a hit present in the cycle after ACK starts a new transfer; no transfer is accepted while in WAIT or ACK.
REQ-024 COUNT increments by 1 per cycle when CNT_EN=1 and wraps 32'hFFFF_FFFF -> 0; a write commit to COUNT takes priority over the increment on that edge.
REQ-025 MATCH sets on any edge where CNT_EN=1 and COUNT==COMPARE; when set and W1C occur on the same edge, set wins.
REQ-026 irq_o = MATCH & IRQ_EN, driven combinationally from registers.

Reset
REQ-027 On wb_rst_i=1 at an edge: FSM to IDLE, all registers 0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0; an in-flight transfer is dropped without ack.
REQ-028 Reset takes priority over every bus and counter event on the same edge.

Configuration
REQ-029 Macro WB_RESPONDER_IRQ_EN: when defined, COMPARE, STATUS, IRQ_EN and irq_o behave per REQ-016/025/026.
REQ-030 When WB_RESPONDER_IRQ_EN is undefined: COMPARE, STATUS and CTRL bit1 read 0, writes to them are acked but ignored, irq_o is tied 0; COUNT and SCRATCH are unaffected.

Verification
REQ-031 WAIT_STATES=1: write 32'hDEAD_BEEF to 0x3000_0000 with sel=4'hF -> ack in cycle N+2 only; read back gives 32'hDEAD_BEEF with ack.
REQ-032 Byte lanes: write 32'h1122_3344 with sel=4'b0101 over SCRATCH1=0 -> readback 32'h0022_0044.
REQ-033 Miss and abort: stb to 0x3000_0040 -> no ack ever; cyc dropped during WAIT on a SCRATCH2 write -> no ack, SCRATCH2 stays 0.
REQ-034 Counter: COMPARE=5, CTRL=3 -> MATCH and irq_o rise after COUNT reaches 5; W1C STATUS=1 clears irq_o; COUNT preset 32'hFFFF_FFFF wraps to 0.
REQ-035 Reset mid-transfer: wb_rst_i in WAIT -> no ack, all readbacks 0; with macro undefined, COMPARE write of 7 reads back 0 and irq_o stays 0.
